pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline registers (F/D, D/E, E/M, M/W).
//  Drives their stall (enable-inverse) and synchronous clear inputs, and the operand forwarding muxes.
//  Owns the multi-cycle MULT/DIV busy sequencer. Instructions reading HI/LO or starting MULT/DIV
//  are held in Decode until the unit finishes.
// PARAMETERS
//  RA_W         5   register address width
//  MULT_CYCLES  5   cycles a MULT occupies the HI/LO unit
//  DIV_CYCLES   10  cycles a DIV occupies the HI/LO unit
//  CNT_W        4   busy counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-high
//  rs_D, rt_D   in   RA_W  Decode source registers
//  use_rs_D     in   1     Decode instr reads rs
//  use_rt_D     in   1     Decode instr reads rt
//  branch_D     in   1     Decode instr compares operands in D (beq/bne/jr)
//  taken_D      in   1     branch/jump in D redirects PC
//  md_use_D     in   1     Decode instr reads HI/LO or is MULT/DIV
//  rs_E, rt_E   in   RA_W  Execute source registers
//  rd_E         in   RA_W  Execute destination
//  regwrite_E   in   1     Execute instr writes register file
//  memtoreg_E   in   1     Execute instr is a load
//  md_start_E   in   1     MULT/DIV issues in Execute this cycle
//  md_div_E     in   1     1 = DIV, 0 = MULT (valid with md_start_E)
//  rd_M         in   RA_W  Memory destination
//  regwrite_M   in   1     Memory instr writes register file
//  memtoreg_M   in   1     Memory instr is a load
//  rd_W         in   RA_W  Writeback destination
//  regwrite_W   in   1     Writeback instr writes register file
//  stall_F      out  1     hold PC / F-D register
//  stall_D      out  1     hold D-E inputs (Decode instr held)
//  clear_D      out  1     clear F/D register (bubble)
//  clear_E      out  1     clear D/E register (bubble)
//  fwdA_D       out  1     rs operand in D taken from M stage result
//  fwdB_D       out  1     rt operand in D taken from M stage result
//  fwdA_E       out  2     rs operand select in E (FWD_RF/FWD_W/FWD_M)
//  fwdB_E       out  2     rt operand select in E
//  md_busy      out  1     HI/LO unit occupied
// BEHAVIOUR
//  - Register 0 never matches. Every hazard compare requires src!=0 and the corresponding use/regwrite bit.
//  - fwdX_E: FWD_M if regwrite_M & rd_M==src_E; else FWD_W if regwrite_W & rd_W==src_E; else FWD_RF.
//    M has priority over W.
//  - fwdX_D = regwrite_M & rd_M==src_D. W data reaches D via write-first register file, so no W forwarding in D.
//  - lw_stall = memtoreg_E & regwrite_E & (rd_E matches a used D source).
//  - br_stall = branch_D & ((regwrite_E & rd_E match) | (memtoreg_M & rd_M match)).
//  - md_stall = md_use_D & (md_busy | md_start_E).
//  - stall_F = stall_D = lw_stall|br_stall|md_stall. clear_E = stall_D.
//  - clear_D = taken_D & ~stall_D. A stalled branch stays in D, and its redirect is honoured once the stall ends.
//  - Stall/clear/fwd outputs are combinational. While reset=1, all of them are forced 0.
//  - MD FSM: IDLE -> BUSY on md_start_E. Counter loads DIV_CYCLES-1 or MULT_CYCLES-1.
//    BUSY decrements each cycle and returns to IDLE the cycle after the counter reaches 0.
//    md_busy = (state==BUSY), registered.
//  - md_start_E while BUSY cannot occur, because md_stall prevents it. If it does occur, the counter is
//    ignored-reloaded? No: the start is ignored and a simulation assertion fires.
//  - Reset, asynchronous and including mid-operation: state=IDLE, counter=0, md_busy=0 immediately.
// STRUCTURE
//  - Shared include/package: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, MD state encodings.
//  - Sub-module md_busy_seq holds the MD FSM and counter (clk, reset, start, is_div -> busy).
//    All other logic is combinational in the top.
// TESTING
//  - add $3 in M, sub uses $3 in E -> fwdA_E=FWD_M. Same reg also in W -> still FWD_M.
//  - lw $5 in E, add reads $5 in D -> stall_F=stall_D=clear_E=1 for 1 cycle, then fwdA_E=FWD_W.
//  - beq $2,$4 in D, add writes $4 in E -> 1-cycle stall. Next cycle fwdB_D=1. Writes to $0 -> no stall.
//  - DIV starts, mflo enters D -> md_busy=1 for 10 cycles, stall_D held until md_busy falls.
//    MULT gives 5 cycles.
//  - taken_D=1 coincident with lw_stall -> clear_D=0. Stall released next cycle -> clear_D=1.
//  - reset asserted mid-DIV (cycle 4) -> md_busy=0 asynchronously. After release, mflo in D -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Purpose  : Shared constants for the pipeline hazard controller.
//            - Forwarding mux select codes for the Execute stage operands.
//            - State encodings of the MULT/DIV busy sequencer.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Execute-stage operand source select
    localparam logic [1:0] c_FWD_RF = 2'b00;  // register file / D-E register value
    localparam logic [1:0] c_FWD_W  = 2'b01;  // Writeback stage result
    localparam logic [1:0] c_FWD_M  = 2'b10;  // Memory stage result

    // MULT/DIV sequencer states
    localparam int                      c_MD_STATE_W = 1;
    localparam logic [c_MD_STATE_W-1:0] c_MD_IDLE    = 1'b0;
    localparam logic [c_MD_STATE_W-1:0] c_MD_BUSY    = 1'b1;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_md_busy_seq.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_seq
// Purpose  : Occupancy sequencer for the multi-cycle HI/LO (MULT/DIV) unit.
//            A start loads the down-counter with (cycles-1); the unit reports
//            busy until the cycle after the counter reaches zero, so busy is
//            high for exactly MULT_CYCLES or DIV_CYCLES cycles.
// Ports    : clk     in  clock, rising edge
//            reset   in  asynchronous, active-high
//            start   in  MULT/DIV issues this cycle
//            is_div  in  1 = DIV, 0 = MULT (qualified by start)
//            busy    out HI/LO unit occupied (decoded from the state register)
// Revision : 1.0  initial release
// ============================================================================
module md_busy_seq
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [c_MD_STATE_W-1:0] r_state;
    logic [c_MD_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_MD_IDLE;
            r_cnt   <= '0;
        end else begin
            // Decode holds any HI/LO user while busy, so a start can never
            // legally arrive here; if it does, it is dropped.
            if (r_state == c_MD_BUSY) begin
                assert (!start);
            end
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_MD_IDLE: begin
                if (start) begin
                    w_state_nxt = c_MD_BUSY;
                    w_cnt_nxt   = is_div ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            c_MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_MD_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == c_MD_BUSY);

endmodule : md_busy_seq
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard/sequencing controller for the 5-stage pipeline registers.
//            Produces stall/clear controls for F/D and D/E, operand forwarding
//            selects for Decode and Execute, and tracks HI/LO unit occupancy.
// Ports    : clk, reset                  clock / async active-high reset
//            rs_D, rt_D, use_rs_D, use_rt_D, branch_D, taken_D, md_use_D
//                                        Decode instruction information
//            rs_E, rt_E, rd_E, regwrite_E, memtoreg_E, md_start_E, md_div_E
//                                        Execute instruction information
//            rd_M, regwrite_M, memtoreg_M Memory instruction information
//            rd_W, regwrite_W            Writeback instruction information
//            stall_F, stall_D            hold PC/F-D and the Decode instruction
//            clear_D, clear_E            bubble F/D and D/E registers
//            fwdA_D, fwdB_D              Decode operand from M-stage result
//            fwdA_E, fwdB_E              Execute operand select (c_FWD_*)
//            md_busy                     HI/LO unit occupied
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] rs_D,
    input  logic [RA_W-1:0] rt_D,
    input  logic            use_rs_D,
    input  logic            use_rt_D,
    input  logic            branch_D,
    input  logic            taken_D,
    input  logic            md_use_D,
    input  logic [RA_W-1:0] rs_E,
    input  logic [RA_W-1:0] rt_E,
    input  logic [RA_W-1:0] rd_E,
    input  logic            regwrite_E,
    input  logic            memtoreg_E,
    input  logic            md_start_E,
    input  logic            md_div_E,
    input  logic [RA_W-1:0] rd_M,
    input  logic            regwrite_M,
    input  logic            memtoreg_M,
    input  logic [RA_W-1:0] rd_W,
    input  logic            regwrite_W,
    output logic            stall_F,
    output logic            stall_D,
    output logic            clear_D,
    output logic            clear_E,
    output logic            fwdA_D,
    output logic            fwdB_D,
    output logic [1:0]      fwdA_E,
    output logic [1:0]      fwdB_E,
    output logic            md_busy
);

    logic       w_e_match;   // E destination matches a used D source
    logic       w_m_match;   // M destination matches a used D source
    logic       w_lw_stall;
    logic       w_br_stall;
    logic       w_md_stall;
    logic       w_stall;
    logic [1:0] w_fwd_a_e;
    logic [1:0] w_fwd_b_e;

    // Register 0 is hard-wired, so a zero destination never creates a hazard.
    assign w_e_match = regwrite_E && (rd_E != '0) &&
                       ((use_rs_D && (rs_D == rd_E)) || (use_rt_D && (rt_D == rd_E)));
    assign w_m_match = regwrite_M && (rd_M != '0) &&
                       ((use_rs_D && (rs_D == rd_M)) || (use_rt_D && (rt_D == rd_M)));

    assign w_lw_stall = memtoreg_E && w_e_match;
    // Branches compare in Decode: an ALU result still in E, or load data not
    // yet available in M, cannot be forwarded there in time.
    assign w_br_stall = branch_D && (w_e_match || (memtoreg_M && w_m_match));
    // A start in E this cycle is counted as busy too, since md_busy rises
    // only after the edge.
    assign w_md_stall = md_use_D && (md_busy || md_start_E);
    assign w_stall    = w_lw_stall || w_br_stall || w_md_stall;

    // M has priority over W: it holds the younger write to the register.
    always_comb begin
        w_fwd_a_e = c_FWD_RF;
        w_fwd_b_e = c_FWD_RF;
        if (regwrite_M && (rs_E != '0) && (rs_E == rd_M)) begin
            w_fwd_a_e = c_FWD_M;
        end else if (regwrite_W && (rs_E != '0) && (rs_E == rd_W)) begin
            w_fwd_a_e = c_FWD_W;
        end
        if (regwrite_M && (rt_E != '0) && (rt_E == rd_M)) begin
            w_fwd_b_e = c_FWD_M;
        end else if (regwrite_W && (rt_E != '0) && (rt_E == rd_W)) begin
            w_fwd_b_e = c_FWD_W;
        end
    end

    // W data reaches Decode through the write-first register file, so only
    // the M result is forwarded into Decode.
    assign fwdA_D  = !reset && regwrite_M && (rs_D != '0) && (rs_D == rd_M);
    assign fwdB_D  = !reset && regwrite_M && (rt_D != '0) && (rt_D == rd_M);
    assign fwdA_E  = reset ? c_FWD_RF : w_fwd_a_e;
    assign fwdB_E  = reset ? c_FWD_RF : w_fwd_b_e;

    assign stall_F = !reset && w_stall;
    assign stall_D = !reset && w_stall;
    assign clear_E = !reset && w_stall;
    // A stalled branch stays in Decode; its redirect is taken once released.
    assign clear_D = !reset && taken_D && !w_stall;

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_div_E),
        .busy   (md_busy)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed vector
//            table, hand-written multi-cycle sequences and randomized traffic
//            against a behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, rd_E, rd_M, rd_W;
    logic       use_rs_D, use_rt_D, branch_D, taken_D, md_use_D;
    logic       regwrite_E, memtoreg_E, md_start_E, md_div_E;
    logic       regwrite_M, memtoreg_M, regwrite_W;
    logic       stall_F, stall_D, clear_D, clear_E, fwdA_D, fwdB_D, md_busy;
    logic [1:0] fwdA_E, fwdB_E;

    int n_cmp = 0;
    int n_bad = 0;
    int m_remain = 0;   // model: cycles of HI/LO occupancy still to come

    pipeline_hazard_ctrl #(
        .RA_W(5), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .branch_D(branch_D), .taken_D(taken_D), .md_use_D(md_use_D),
        .rs_E(rs_E), .rt_E(rt_E), .rd_E(rd_E), .regwrite_E(regwrite_E),
        .memtoreg_E(memtoreg_E), .md_start_E(md_start_E), .md_div_E(md_div_E),
        .rd_M(rd_M), .regwrite_M(regwrite_M), .memtoreg_M(memtoreg_M),
        .rd_W(rd_W), .regwrite_W(regwrite_W),
        .stall_F(stall_F), .stall_D(stall_D), .clear_D(clear_D), .clear_E(clear_E),
        .fwdA_D(fwdA_D), .fwdB_D(fwdB_D), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs_d, rt_d;
        logic       use_rs, use_rt, br, tk, mdu;
        logic [4:0] rs_e, rt_e, rd_e;
        logic       rw_e, mr_e, mds;
        logic [4:0] rd_m;
        logic       rw_m, mr_m;
        logic [4:0] rd_w;
        logic       rw_w;
        logic       x_stall, x_clr_d, x_fa_d, x_fb_d;
        logic [1:0] x_fa_e, x_fb_e;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(string nm, int rsd, int rtd, int ur, int ut, int br, int tk, int mdu,
                           int rse, int rte, int rde, int rwe, int mre, int mds,
                           int rdm, int rwm, int mrm, int rdw, int rww,
                           int xs, int xc, int xfad, int xfbd, int xfae, int xfbe);
        vec_t v;
        v.rs_d = rsd[4:0]; v.rt_d = rtd[4:0]; v.use_rs = ur[0]; v.use_rt = ut[0];
        v.br = br[0]; v.tk = tk[0]; v.mdu = mdu[0];
        v.rs_e = rse[4:0]; v.rt_e = rte[4:0]; v.rd_e = rde[4:0];
        v.rw_e = rwe[0]; v.mr_e = mre[0]; v.mds = mds[0];
        v.rd_m = rdm[4:0]; v.rw_m = rwm[0]; v.mr_m = mrm[0];
        v.rd_w = rdw[4:0]; v.rw_w = rww[0];
        v.x_stall = xs[0]; v.x_clr_d = xc[0]; v.x_fa_d = xfad[0]; v.x_fb_d = xfbd[0];
        v.x_fa_e = xfae[1:0]; v.x_fb_e = xfbe[1:0];
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; use_rs_D = 0; use_rt_D = 0; branch_D = 0; taken_D = 0;
        md_use_D = 0; rs_E = 0; rt_E = 0; rd_E = 0; regwrite_E = 0; memtoreg_E = 0;
        md_start_E = 0; md_div_E = 0; rd_M = 0; regwrite_M = 0; memtoreg_M = 0;
        rd_W = 0; regwrite_W = 0;
    endtask

    // A writer produces a hazard on a source when the source is actually read,
    // the writer writes, and the register is a real one (not $0).
    function automatic bit hits(logic [4:0] src, bit used, logic [4:0] dst, bit wr);
        return used && wr && (src != 0) && (src == dst);
    endfunction

    function automatic int fwd_e_model(logic [4:0] src);
        if (hits(src, 1'b1, rd_M, regwrite_M)) return 2;
        if (hits(src, 1'b1, rd_W, regwrite_W)) return 1;
        return 0;
    endfunction

    task automatic check_all(string tag);
        logic [4:0] src[2];
        bit         used[2];
        bit lw = 0, br = 0, md, st, cd, fad, fbd;
        int fae, fbe, busy;
        src[0] = rs_D; src[1] = rt_D; used[0] = use_rs_D; used[1] = use_rt_D;
        foreach (src[k]) begin
            if (memtoreg_E && hits(src[k], used[k], rd_E, regwrite_E)) lw = 1;
            if (branch_D && (hits(src[k], used[k], rd_E, regwrite_E) ||
                             hits(src[k], used[k], rd_M, regwrite_M && memtoreg_M))) br = 1;
        end
        busy = (m_remain > 0) ? 1 : 0;
        md   = md_use_D && ((busy != 0) || md_start_E);
        st   = lw || br || md;
        cd   = taken_D && !st;
        fad  = hits(rs_D, 1'b1, rd_M, regwrite_M);
        fbd  = hits(rt_D, 1'b1, rd_M, regwrite_M);
        fae  = fwd_e_model(rs_E);
        fbe  = fwd_e_model(rt_E);
        if (reset) begin
            st = 0; cd = 0; fad = 0; fbd = 0; fae = 0; fbe = 0; busy = 0;
        end
        chk({tag, ".stall_F"}, stall_F, st);
        chk({tag, ".stall_D"}, stall_D, st);
        chk({tag, ".clear_E"}, clear_E, st);
        chk({tag, ".clear_D"}, clear_D, cd);
        chk({tag, ".fwdA_D"},  fwdA_D,  fad);
        chk({tag, ".fwdB_D"},  fwdB_D,  fbd);
        chk({tag, ".fwdA_E"},  fwdA_E,  fae);
        chk({tag, ".fwdB_E"},  fwdB_E,  fbe);
        chk({tag, ".md_busy"}, md_busy, busy);
    endtask

    // Model of the HI/LO unit across one rising edge.
    task automatic model_edge();
        if (reset)              m_remain = 0;
        else if (m_remain > 0)  m_remain = m_remain - 1;
        else if (md_start_E)    m_remain = md_div_E ? 10 : 5;
    endtask

    // Called 3 time units after an edge: check, then advance one cycle.
    task automatic adv(string tag);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        //           name            rsD rtD ur ut br tk mu rsE rtE rdE rwE mrE mds rdM rwM mrM rdW rwW  st cD fAD fBD fAE fBE
        add_vec("fwd_m",             0,  0,  0, 0, 0, 0, 0,  3,  0,  0,  0,  0,  0,  3,  1,  0,  0,  0,   0, 0, 0,  0,  2,  0);
        add_vec("fwd_m_over_w",      0,  0,  0, 0, 0, 0, 0,  3,  0,  0,  0,  0,  0,  3,  1,  0,  3,  1,   0, 0, 0,  0,  2,  0);
        add_vec("fwd_w",             0,  0,  0, 0, 0, 0, 0,  3,  3,  0,  0,  0,  0,  0,  0,  0,  3,  1,   0, 0, 0,  0,  1,  1);
        add_vec("fwd_r0",            0,  0,  0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,   0, 0, 0,  0,  0,  0);
        add_vec("lw_stall",          5,  0,  1, 0, 0, 0, 0,  0,  0,  5,  1,  1,  0,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0);
        add_vec("lw_unused",         5,  0,  0, 0, 0, 0, 0,  0,  0,  5,  1,  1,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0);
        add_vec("lw_rt",             0,  5,  0, 1, 0, 0, 0,  0,  0,  5,  1,  1,  0,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0);
        add_vec("br_stall_e",        2,  4,  1, 1, 1, 0, 0,  0,  0,  4,  1,  0,  0,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0);
        add_vec("br_r0",             2,  0,  1, 1, 1, 0, 0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0);
        add_vec("alu_no_stall",      2,  4,  1, 1, 0, 0, 0,  0,  0,  4,  1,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0);
        add_vec("br_fwdB_D",         2,  4,  1, 1, 1, 0, 0,  0,  0,  0,  0,  0,  0,  4,  1,  0,  0,  0,   0, 0, 0,  1,  0,  0);
        add_vec("br_load_m",         2,  4,  1, 1, 1, 0, 0,  0,  0,  0,  0,  0,  0,  2,  1,  1,  0,  0,   1, 0, 1,  0,  0,  0);
        add_vec("taken_lw",          5,  0,  1, 0, 0, 1, 0,  0,  0,  5,  1,  1,  0,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0);
        add_vec("taken",             0,  0,  0, 0, 0, 1, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0, 1, 0,  0,  0,  0);
        add_vec("md_start_use",      0,  0,  0, 0, 0, 0, 1,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0);
        add_vec("md_start_nouse",    0,  0,  0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0);

        // Reset state: hazard-provoking inputs must still give all-zero outputs.
        clear_inputs();
        reset = 1;
        rs_D = 5; use_rs_D = 1; rd_E = 5; regwrite_E = 1; memtoreg_E = 1; taken_D = 1;
        rs_E = 3; rd_M = 3; regwrite_M = 1; md_use_D = 1; md_start_E = 1;
        #3;
        chk("reset.stall_D", stall_D, 0);
        chk("reset.clear_D", clear_D, 0);
        check_all("reset");
        @(posedge clk); model_edge(); #1;
        clear_inputs();
        #3 reset = 0;
        @(posedge clk); model_edge(); #1;

        // Directed vector table; inputs are zeroed before each edge so
        // md_start_E pulses never reach the sequencer.
        for (int i = 0; i < vecs.size(); i++) begin
            rs_D = vecs[i].rs_d; rt_D = vecs[i].rt_d; use_rs_D = vecs[i].use_rs;
            use_rt_D = vecs[i].use_rt; branch_D = vecs[i].br; taken_D = vecs[i].tk;
            md_use_D = vecs[i].mdu; rs_E = vecs[i].rs_e; rt_E = vecs[i].rt_e;
            rd_E = vecs[i].rd_e; regwrite_E = vecs[i].rw_e; memtoreg_E = vecs[i].mr_e;
            md_start_E = vecs[i].mds; rd_M = vecs[i].rd_m; regwrite_M = vecs[i].rw_m;
            memtoreg_M = vecs[i].mr_m; rd_W = vecs[i].rd_w; regwrite_W = vecs[i].rw_w;
            #2;
            chk({names[i], ".stall_F"}, stall_F, vecs[i].x_stall);
            chk({names[i], ".stall_D"}, stall_D, vecs[i].x_stall);
            chk({names[i], ".clear_E"}, clear_E, vecs[i].x_stall);
            chk({names[i], ".clear_D"}, clear_D, vecs[i].x_clr_d);
            chk({names[i], ".fwdA_D"},  fwdA_D,  vecs[i].x_fa_d);
            chk({names[i], ".fwdB_D"},  fwdB_D,  vecs[i].x_fb_d);
            chk({names[i], ".fwdA_E"},  fwdA_E,  vecs[i].x_fa_e);
            chk({names[i], ".fwdB_E"},  fwdB_E,  vecs[i].x_fb_e);
            #1 clear_inputs();
            @(posedge clk); #1;
        end

        // lw $5 in E, add reads $5 in D: one stall, then bubble, then W forward.
        clear_inputs(); rd_E = 5; regwrite_E = 1; memtoreg_E = 1; rs_D = 5; use_rs_D = 1;
        #2 chk("lw1.stall_D", stall_D, 1); adv("lw1");
        clear_inputs(); rs_D = 5; use_rs_D = 1; rd_M = 5; regwrite_M = 1; memtoreg_M = 1;
        #2 chk("lw2.stall_D", stall_D, 0); adv("lw2");
        clear_inputs(); rs_E = 5; rd_W = 5; regwrite_W = 1;
        #2 chk("lw3.fwdA_E", fwdA_E, 1); adv("lw3");

        // Taken beq $2,$4 with $4 written in E: stall, then forward and redirect.
        clear_inputs(); rs_D = 2; rt_D = 4; use_rs_D = 1; use_rt_D = 1; branch_D = 1;
        taken_D = 1; rd_E = 4; regwrite_E = 1;
        #2 chk("br1.clear_D", clear_D, 0); adv("br1");
        rd_E = 0; regwrite_E = 0; rd_M = 4; regwrite_M = 1;
        #2 chk("br2.fwdB_D", fwdB_D, 1); chk("br2.clear_D", clear_D, 1); adv("br2");

        // DIV then MULT with the HI/LO reader held in Decode.
        for (int d = 1; d >= 0; d--) begin
            clear_inputs(); md_start_E = 1; md_div_E = d[0]; md_use_D = 1;
            #2 adv("md_start");
            md_start_E = 0; md_div_E = 0;
            busy_cnt = 0;
            for (int c = 0; c < 13; c++) begin
                #2 if (md_busy) busy_cnt++;
                adv("md_run");
            end
            chk(d ? "div.busy_cycles" : "mult.busy_cycles", busy_cnt, d ? 10 : 5);
        end

        // Reset asserted mid-DIV, then mflo in Decode must not stall.
        clear_inputs(); md_start_E = 1; md_div_E = 1;
        #2 adv("rdiv0");
        clear_inputs(); md_use_D = 1;
        for (int c = 0; c < 3; c++) begin
            #2 adv("rdiv");
        end
        #1 reset = 1; m_remain = 0;
        #1 chk("rst_mid.md_busy", md_busy, 0);
        chk("rst_mid.stall_D", stall_D, 0);
        @(posedge clk); model_edge(); #3 reset = 0;
        @(posedge clk); model_edge(); #1;
        #2 chk("post_rst.stall_D", stall_D, 0); adv("post_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
            use_rs_D = 1'($urandom); use_rt_D = 1'($urandom);
            branch_D = ($urandom_range(0, 3) == 0); taken_D = 1'($urandom);
            md_use_D = ($urandom_range(0, 3) == 0);
            rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
            rd_E = 5'($urandom_range(0, 3));
            memtoreg_E = 1'($urandom); regwrite_E = memtoreg_E | 1'($urandom);
            rd_M = 5'($urandom_range(0, 3));
            memtoreg_M = 1'($urandom); regwrite_M = memtoreg_M | 1'($urandom);
            rd_W = 5'($urandom_range(0, 3)); regwrite_W = 1'($urandom);
            md_start_E = (m_remain == 0) && ($urandom_range(0, 9) == 0);
            md_div_E = 1'($urandom);
            #2 adv("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
